// File: rtl/digital_clock_ctrl.sv
// digital_clock_ctrl: 24 h BCD timekeeper with a prescaled 1 Hz tick, a
// key-driven field adjust FSM, 12/24 h display conversion, hourly chime,
// hh:mm alarm and a blink strobe for the field being adjusted.
// key_sel / key_inc are single-cycle, already-debounced pulses: each cycle
// they are high counts as one press, and key_sel beats key_inc.
module digital_clock_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       cr,
  input  logic       mode_12h,
  input  logic       key_sel,
  input  logic       key_inc,
  input  logic       alarm_en,
  input  logic [7:0] alarm_h,
  input  logic [7:0] alarm_m,
  output logic [3:0] bcd_su,
  output logic [3:0] bcd_st,
  output logic [3:0] bcd_mu,
  output logic [3:0] bcd_mt,
  output logic [3:0] bcd_hu,
  output logic [3:0] bcd_ht,
  output logic       pm,
  output logic [1:0] sel_field,
  output logic       blink,
  output logic       tick,
  output logic       chime,
  output logic       alarm
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3} state_e;

  state_e        state_q;
  logic [TW-1:0] pre_q, pre_d;
  logic [BW-1:0] bl_cnt_q;
  logic          blink_q, chime_q, alarm_q;
  logic [3:0]    su_q, st_q, mu_q, mt_q, hu_q, ht_q;
  logic [3:0]    su_d, st_d, mu_d, mt_d, hu_d, ht_d;
  logic [3:0]    hn_t, hn_u, mn_t, mn_u;
  logic          tick_w, inc_w, sec_wrap, min_wrap, min_roll, hour_roll, alarm_hit;
  logic [4:0]    h_bin, h_disp;

  assign tick_w    = (pre_q == TW'(TICK_DIV - 1));
  assign inc_w     = key_inc & ~key_sel;
  assign sec_wrap  = (st_q == 4'd5) && (su_q == 4'd9);
  assign min_wrap  = (mt_q == 4'd5) && (mu_q == 4'd9);
  assign min_roll  = (state_q == RUN) && tick_w && sec_wrap;
  assign hour_roll = min_roll && min_wrap;

  // Field successors without carry-out: hour 23->00, minute 59->00
  always_comb begin
    if (ht_q == 4'd2 && hu_q == 4'd3) begin
      hn_t = 4'd0; hn_u = 4'd0;
    end else if (hu_q == 4'd9) begin
      hn_t = ht_q + 4'd1; hn_u = 4'd0;
    end else begin
      hn_t = ht_q; hn_u = hu_q + 4'd1;
    end
    if (min_wrap) begin
      mn_t = 4'd0; mn_u = 4'd0;
    end else if (mu_q == 4'd9) begin
      mn_t = mt_q + 4'd1; mn_u = 4'd0;
    end else begin
      mn_t = mt_q; mn_u = mu_q + 4'd1;
    end
  end

  // Next time and prescaler: ticks advance with carry only in RUN, keys adjust one field in SET
  always_comb begin
    su_d = su_q; st_d = st_q; mu_d = mu_q; mt_d = mt_q; hu_d = hu_q; ht_d = ht_q;
    pre_d = tick_w ? '0 : pre_q + TW'(1);
    unique case (state_q)
      RUN: begin
        if (tick_w) begin
          if (sec_wrap) begin
            su_d = 4'd0; st_d = 4'd0;
            mt_d = mn_t; mu_d = mn_u;
            if (min_wrap) begin
              ht_d = hn_t; hu_d = hn_u;
            end
          end else if (su_q == 4'd9) begin
            su_d = 4'd0; st_d = st_q + 4'd1;
          end else begin
            su_d = su_q + 4'd1;
          end
        end
      end
      SET_HOUR: if (inc_w) begin ht_d = hn_t; hu_d = hn_u; end
      SET_MIN:  if (inc_w) begin mt_d = mn_t; mu_d = mn_u; end
      SET_SEC:  if (inc_w) begin su_d = 4'd0; st_d = 4'd0; pre_d = '0; end
    endcase
  end

  // Internal time is legal BCD, so an out-of-range alarm value can never compare equal
  assign alarm_hit = alarm_en && min_roll && ({ht_d, hu_d} == alarm_h) && ({mt_d, mu_d} == alarm_m);

  // Time and prescaler registers
  always_ff @(posedge clk) begin
    if (cr) begin
      su_q <= 4'd0; st_q <= 4'd0; mu_q <= 4'd0; mt_q <= 4'd0; hu_q <= 4'd0; ht_q <= 4'd0;
      pre_q <= '0;
    end else begin
      su_q <= su_d; st_q <= st_d; mu_q <= mu_d; mt_q <= mt_d; hu_q <= hu_d; ht_q <= ht_d;
      pre_q <= pre_d;
    end
  end

  // Adjust FSM with registered blink, chime and alarm outputs
  always_ff @(posedge clk) begin
    if (cr) begin
      state_q  <= RUN;
      bl_cnt_q <= '0;
      blink_q  <= 1'b1;
      chime_q  <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      chime_q <= hour_roll;
      if (key_sel) begin
        unique case (state_q)
          RUN:      state_q <= SET_HOUR;
          SET_HOUR: state_q <= SET_MIN;
          SET_MIN:  state_q <= SET_SEC;
          SET_SEC:  state_q <= RUN;
        endcase
        bl_cnt_q <= '0;
        blink_q  <= 1'b1;
      end else if (state_q == RUN) begin
        bl_cnt_q <= '0;
        blink_q  <= 1'b1;
      end else if (bl_cnt_q == BW'(BLINK_DIV - 1)) begin
        bl_cnt_q <= '0;
        blink_q  <= ~blink_q;
      end else begin
        bl_cnt_q <= bl_cnt_q + BW'(1);
      end
      // clear conditions win; a minute rollover re-evaluates the match
      if (!alarm_en || (key_sel && state_q == RUN)) alarm_q <= 1'b0;
      else if (min_roll) alarm_q <= alarm_hit;
    end
  end

  // Display conversion: 24 h pass-through, or 12 h with 00 shown as 12
  assign h_bin = 5'(ht_q) * 5'd10 + 5'(hu_q);
  always_comb begin
    h_disp = h_bin;
    pm     = 1'b0;
    bcd_ht = ht_q;
    bcd_hu = hu_q;
    if (mode_12h) begin
      if (h_bin == 5'd0) h_disp = 5'd12;
      else if (h_bin >= 5'd12) begin
        pm = 1'b1;
        if (h_bin > 5'd12) h_disp = h_bin - 5'd12;
      end
      if (h_disp >= 5'd10) begin
        bcd_ht = 4'd1; bcd_hu = 4'(h_disp - 5'd10);
      end else begin
        bcd_ht = 4'd0; bcd_hu = h_disp[3:0];
      end
    end
  end

  assign bcd_su    = su_q;
  assign bcd_st    = st_q;
  assign bcd_mu    = mu_q;
  assign bcd_mt    = mt_q;
  assign sel_field = state_q;
  assign blink     = blink_q;
  assign tick      = tick_w;
  assign chime     = chime_q;
  assign alarm     = alarm_q;
endmodule

// File: tb/tb_digital_clock_ctrl.sv
// Bench for digital_clock_ctrl: time kept as seconds-of-day in a model,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_digital_clock_ctrl;
  localparam int TD = 4;
  localparam int BD = 2;

  logic       clk = 1'b0;
  logic       cr = 1'b1, mode_12h = 1'b0, key_sel = 1'b0, key_inc = 1'b0, alarm_en = 1'b0;
  logic [7:0] alarm_h = 8'h00, alarm_m = 8'h00;
  logic [3:0] bcd_su, bcd_st, bcd_mu, bcd_mt, bcd_hu, bcd_ht;
  logic       pm, blink, tick, chime, alarm;
  logic [1:0] sel_field;

  int n_checks = 0, n_pass = 0;
  int chime_seen = 0, tick_seen = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  digital_clock_ctrl #(.TICK_DIV(TD), .BLINK_DIV(BD)) dut (
    .clk(clk), .cr(cr), .mode_12h(mode_12h), .key_sel(key_sel), .key_inc(key_inc),
    .alarm_en(alarm_en), .alarm_h(alarm_h), .alarm_m(alarm_m),
    .bcd_su(bcd_su), .bcd_st(bcd_st), .bcd_mu(bcd_mu), .bcd_mt(bcd_mt),
    .bcd_hu(bcd_hu), .bcd_ht(bcd_ht), .pm(pm), .sel_field(sel_field),
    .blink(blink), .tick(tick), .chime(chime), .alarm(alarm)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_secs = 0, m_mode = 0, m_pre = 0, m_age = 0;
  bit m_chime = 0, m_alarm = 0, m_tk, m_roll;
  int m_h, m_m, m_s;

  function automatic bit alarm_match(input int secs, input logic [7:0] ah, input logic [7:0] am);
    if (ah[7:4] > 9 || ah[3:0] > 9 || am[7:4] > 9 || am[3:0] > 9) return 1'b0;
    return ((ah[7:4] * 10 + ah[3:0]) == secs / 3600) && ((am[7:4] * 10 + am[3:0]) == (secs / 60) % 60);
  endfunction

  always @(posedge clk) begin
    if (cr) begin
      m_secs = 0; m_mode = 0; m_pre = 0; m_age = 0; m_chime = 0; m_alarm = 0;
    end else begin
      m_tk = (m_pre == TD - 1);
      m_roll = 0;
      m_chime = 0;
      if (m_mode == 0 && m_tk) begin
        m_secs = (m_secs + 1) % 86400;
        m_roll = (m_secs % 60 == 0);
        m_chime = (m_secs % 3600 == 0);
      end
      m_pre = m_tk ? 0 : m_pre + 1;
      if (key_inc && !key_sel) begin
        m_h = m_secs / 3600; m_m = (m_secs / 60) % 60; m_s = m_secs % 60;
        case (m_mode)
          1: m_secs = ((m_h + 1) % 24) * 3600 + m_m * 60 + m_s;
          2: m_secs = m_h * 3600 + ((m_m + 1) % 60) * 60 + m_s;
          3: begin m_secs = m_h * 3600 + m_m * 60; m_pre = 0; end
          default: ;
        endcase
      end
      if (!alarm_en || (key_sel && m_mode == 0)) m_alarm = 0;
      else if (m_roll) m_alarm = alarm_match(m_secs, alarm_h, alarm_m);
      if (key_sel) begin m_mode = (m_mode + 1) % 4; m_age = 0; end
      else if (m_mode != 0) m_age++;
    end
  end

  // ---------------- compare process (every cycle) ----------------
  int e_h, e_dh, e_pm;
  always @(posedge clk) begin
    #1;
    e_h = m_secs / 3600;
    if (mode_12h) begin e_pm = (e_h >= 12); e_dh = (e_h % 12 == 0) ? 12 : e_h % 12; end
    else begin e_pm = 0; e_dh = e_h; end
    chk("bcd_ht", bcd_ht, e_dh / 10);
    chk("bcd_hu", bcd_hu, e_dh % 10);
    chk("bcd_mt", bcd_mt, ((m_secs / 60) % 60) / 10);
    chk("bcd_mu", bcd_mu, ((m_secs / 60) % 60) % 10);
    chk("bcd_st", bcd_st, (m_secs % 60) / 10);
    chk("bcd_su", bcd_su, (m_secs % 60) % 10);
    chk("pm", pm, e_pm);
    chk("sel_field", sel_field, m_mode);
    chk("blink", blink, (m_mode == 0) ? 1 : (((m_age / BD) % 2) == 0 ? 1 : 0));
    chk("tick", tick, (m_pre == TD - 1) ? 1 : 0);
    chk("chime", chime, m_chime);
    chk("alarm", alarm, m_alarm);
    if (chime) chime_seen++;
    if (tick) tick_seen++;
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    cr = 1'b1; @(negedge clk); cr = 1'b0;
  endtask

  task automatic press_sel();
    @(negedge clk); key_sel = 1'b1; @(negedge clk); key_sel = 1'b0;
  endtask

  task automatic press_inc();
    @(negedge clk); key_inc = 1'b1; @(negedge clk); key_inc = 1'b0;
  endtask

  task automatic hour_to(input int h);
    repeat ((h - m_secs / 3600 + 24) % 24) press_inc();
  endtask

  task automatic min_to(input int m);
    repeat ((m - (m_secs / 60) % 60 + 60) % 60) press_inc();
  endtask

  // from RUN: set hh:mm, clear seconds and prescaler, back to RUN
  task automatic set_time(input int h, input int m);
    press_sel(); hour_to(h);
    press_sel(); min_to(m);
    press_sel(); press_inc();
    press_sel();
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    chk({tag, "_ht"}, bcd_ht, h / 10); chk({tag, "_hu"}, bcd_hu, h % 10);
    chk({tag, "_mt"}, bcd_mt, m / 10); chk({tag, "_mu"}, bcd_mu, m % 10);
    chk({tag, "_st"}, bcd_st, s / 10); chk({tag, "_su"}, bcd_su, s % 10);
  endtask

  int c0, t0, toggles, hh;
  logic prev_b;

  // ---------------- main sequence ----------------
  initial begin
    do_reset();
    check_time("rst", 0, 0, 0);
    chk("rst_pm", pm, 0); chk("rst_sel", sel_field, 0); chk("rst_blink", blink, 1);
    chk("rst_tick", tick, 0); chk("rst_chime", chime, 0); chk("rst_alarm", alarm, 0);

    // free run one minute
    c0 = chime_seen; t0 = tick_seen;
    idle(240);
    check_time("run240", 0, 1, 0);
    chk("run240_chime", chime_seen - c0, 0);
    chk("run240_ticks", tick_seen - t0, 60);

    // 00:59 -> 01:00:00 with one chime
    set_time(0, 59);
    c0 = chime_seen;
    idle(240);
    check_time("hour_roll", 1, 0, 0);
    chk("hour_roll_chime", chime_seen - c0, 1);

    // 23:59 -> 00:00:00 with one chime
    set_time(23, 59);
    c0 = chime_seen;
    idle(240);
    check_time("day_roll", 0, 0, 0);
    chk("day_roll_chime", chime_seen - c0, 1);

    // SET_MIN wrap, frozen time, blink rate
    press_sel(); hour_to(5);
    press_sel(); min_to(59);
    chk("setmin_mt59", bcd_mt, 5); chk("setmin_mu59", bcd_mu, 9);
    press_inc();
    chk("setmin_wrap_mt", bcd_mt, 0); chk("setmin_wrap_mu", bcd_mu, 0);
    chk("setmin_hour", bcd_hu, 5);
    toggles = 0;
    for (int i = 0; i < 40; i++) begin
      prev_b = blink; @(negedge clk);
      if (blink != prev_b) toggles++;
    end
    chk("hold_toggles", toggles, 20);
    chk("hold_sel", sel_field, 2);
    chk("hold_mu", bcd_mu, 0); chk("hold_hu", bcd_hu, 5);
    press_sel(); press_sel();

    // 12/24 h display
    press_sel(); hour_to(0);
    mode_12h = 1'b1; idle(1);
    chk("h00_ht", bcd_ht, 1); chk("h00_hu", bcd_hu, 2); chk("h00_pm", pm, 0);
    hour_to(12); idle(1);
    chk("h12_ht", bcd_ht, 1); chk("h12_hu", bcd_hu, 2); chk("h12_pm", pm, 1);
    hour_to(13); idle(1);
    chk("h13_ht", bcd_ht, 0); chk("h13_hu", bcd_hu, 1); chk("h13_pm", pm, 1);
    mode_12h = 1'b0; idle(1);
    chk("h13_24_ht", bcd_ht, 1); chk("h13_24_hu", bcd_hu, 3); chk("h13_24_pm", pm, 0);
    press_sel(); press_sel(); press_sel();

    // alarm 07:30
    alarm_h = 8'h07; alarm_m = 8'h30; alarm_en = 1'b1;
    set_time(7, 29);
    idle(240);
    check_time("al_rise", 7, 30, 0); chk("al_rise", alarm, 1);
    idle(236);
    chk("al_hold", alarm, 1); chk("al_hold_su", bcd_su, 9);
    idle(4);
    chk("al_clear", alarm, 0); chk("al_clear_mu", bcd_mu, 1);
    set_time(7, 29);
    idle(240);
    chk("al_rise2", alarm, 1);
    alarm_en = 1'b0; idle(1);
    chk("al_dis", alarm, 0);

    // key_sel beats key_inc; reset beats key_inc
    do_reset();
    press_sel();
    @(negedge clk); key_sel = 1'b1; key_inc = 1'b1; @(negedge clk); key_sel = 1'b0; key_inc = 1'b0;
    chk("both_sel", sel_field, 2); chk("both_hu", bcd_hu, 0); chk("both_ht", bcd_ht, 0);
    press_inc();
    chk("min_inc", bcd_mu, 1);
    cr = 1'b1; key_inc = 1'b1; @(negedge clk); cr = 1'b0; key_inc = 1'b0;
    check_time("cr_inc", 0, 0, 0);
    chk("cr_sel", sel_field, 0); chk("cr_blink", blink, 1);

    // randomized stimulus against the model
    alarm_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      key_sel  = ($urandom_range(0, 15) == 0);
      key_inc  = ($urandom_range(0, 2) == 0);
      cr       = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 49) == 0) mode_12h = $urandom_range(0, 1);
      if ($urandom_range(0, 99) == 0) alarm_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          alarm_h = 8'($urandom_range(0, 255)); alarm_m = 8'($urandom_range(0, 255));
        end else begin
          hh = m_secs / 3600;
          alarm_h = 8'((hh / 10) * 16 + hh % 10);
          hh = ((m_secs / 60) + 1) % 60;
          alarm_m = 8'((hh / 10) * 16 + hh % 10);
        end
      end
      @(negedge clk);
    end
    key_sel = 1'b0; key_inc = 1'b0; cr = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
